// File: rtl/btn_event_queue.sv
// btn_event_queue: button input stage for the game logic.
// Each raw button is synchronised, debounced and edge-detected. Press edges
// are queued as one pending bit per button and presented one at a time on
// a valid/ready output register.
//
// Handshake: evt_valid/evt_idx form the output register. An event transfers
// on every rising clk edge where evt_valid && evt_ready. While evt_valid is
// high and evt_ready is low, evt_idx holds stable. evt_ready is ignored while
// evt_valid is low.
//
// IDX_W must satisfy 2**IDX_W >= N_BTN.
module btn_event_queue #(
   parameter int N_BTN           = 7,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int IDX_W           = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_async,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_idx,
   output logic             overflow,
   input  logic             overflow_clr
);

   // Counter must reach DEBOUNCE_CYCLES-1; keep at least one bit.
   localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser stages; sync2_q is the synchronised sample s[i].
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   // Debounce state.
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];
   logic [N_BTN-1:0] level_q;
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] pulse_q;
   logic [N_BTN-1:0] pulse_d;

   // Event queue state.
   logic [N_BTN-1:0] pend_q;
   logic [N_BTN-1:0] pend_d;
   logic             valid_q;
   logic             valid_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             ovf_q;
   logic             ovf_d;

   // Selection helpers.
   logic [N_BTN-1:0] sel_mask;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_any;
   logic             load_en;
   logic [N_BTN-1:0] load_mask;
   logic [N_BTN-1:0] pend_keep;

   // Two-flop synchroniser on every raw button pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_async;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive samples that disagree with the accepted
   // level; toggle the level once the count reaches its limit.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // Pulse lines up with the first cycle the level reads 1.
      pulse_d = level_d & ~level_q;
   end

   // Debounce counters, accepted levels and press pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
         level_q <= '0;
         pulse_q <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   // Lowest-index pending bit, as a one-hot mask and as an index.
   always_comb begin
      sel_mask = pend_q & (~pend_q + N_BTN'(1));
      sel_any  = |pend_q;
      sel_idx  = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   // Output register load, pending-bit update and sticky overflow.
   always_comb begin
      // Load when the register is empty or its event is being taken.
      load_en   = !valid_q || evt_ready;
      load_mask = load_en ? sel_mask : '0;
      valid_d   = load_en ? sel_any : valid_q;
      idx_d     = (load_en && sel_any) ? sel_idx : idx_q;
      // A press on a bit that is leaving this cycle is a fresh event and
      // re-arms it; a press on a bit that stays pending is lost.
      pend_keep = pend_q & ~load_mask;
      pend_d    = pend_keep | pulse_q;
      ovf_d     = ovf_q;
      if (overflow_clr) begin
         ovf_d = 1'b0;
      end
      if (|(pulse_q & pend_keep)) begin
         ovf_d = 1'b1;
      end
   end

   // Event queue registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
      end
   end

   assign btn_level   = level_q;
   assign press_pulse = pulse_q;
   assign evt_valid   = valid_q;
   assign evt_idx     = idx_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue with a short debounce window.
module tb_btn_event_queue;

   localparam int N = 7;
   localparam int D = 4;
   localparam int W = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] btn_async;
   logic [N-1:0] btn_level;
   logic [N-1:0] press_pulse;
   logic         evt_valid;
   logic         evt_ready;
   logic [W-1:0] evt_idx;
   logic         overflow;
   logic         overflow_clr;

   int           n_checks;
   int           n_errors;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           pulse_cnt [N];

   btn_event_queue #(
      .N_BTN          (N),
      .DEBOUNCE_CYCLES(D),
      .IDX_W          (W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_async   (btn_async),
      .btn_level   (btn_level),
      .press_pulse (press_pulse),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_idx     (evt_idx),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: record accepted events and press pulses mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (evt_valid && evt_ready) got_q.push_back(evt_idx);
         for (int i = 0; i < N; i++) begin
            if (press_pulse[i]) pulse_cnt[i]++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next n rising edges.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_pulses();
      for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
   endtask

   // Compare delivered events against the expected queue, then empty both.
   task automatic check_events(input string tag);
      int n;
      check($sformatf("%s_nevt", tag), got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      btn_async    = '0;
      evt_ready    = 1'b0;
      overflow_clr = 1'b0;
      clear_pulses();
      tick(2);

      // Reset state
      check("rst_level", 32'(btn_level), 32'd0);
      check("rst_pulse", 32'(press_pulse), 32'd0);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_ovf",   32'(overflow), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Clean press of button 3, consumer always ready
      evt_ready    = 1'b1;
      clear_pulses();
      btn_async[3] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick(1);
         check($sformatf("t1_lvl_%0d", n), 32'(btn_level[3]), 32'(n >= 6));
         check($sformatf("t1_pulse_%0d", n), 32'(press_pulse), 32'((n == 6) ? 7'h08 : 7'h00));
         check($sformatf("t1_valid_%0d", n), 32'(evt_valid), 32'(n == 8));
         if (n == 8) check("t1_idx", 32'(evt_idx), 32'd3);
      end
      exp_q.push_back(3'd3);
      btn_async[3] = 1'b0;
      tick(8);
      check("t1_lvl_rel", 32'(btn_level[3]), 32'd0);
      check("t1_npulse", pulse_cnt[3], 1);
      check_events("t1");

      // Bouncing button 0, then held
      clear_pulses();
      for (int c = 0; c < 5; c++) begin
         btn_async[0] = 1'b1;
         tick(2);
         btn_async[0] = 1'b0;
         tick(2);
      end
      check("t2_bounce_pulse", pulse_cnt[0], 0);
      check("t2_bounce_lvl", 32'(btn_level[0]), 32'd0);
      btn_async[0] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick(1);
         check($sformatf("t2_pulse_%0d", n), 32'(press_pulse[0]), 32'(n == 6));
      end
      exp_q.push_back(3'd0);
      btn_async[0] = 1'b0;
      tick(8);
      check("t2_npulse", pulse_cnt[0], 1);
      check_events("t2");

      // Buttons 5 and 1 together under backpressure
      evt_ready    = 1'b0;
      btn_async[5] = 1'b1;
      btn_async[1] = 1'b1;
      tick(8);
      check("t3_valid", 32'(evt_valid), 32'd1);
      check("t3_idx", 32'(evt_idx), 32'd1);
      for (int s = 1; s <= 10; s++) begin
         tick(1);
         check($sformatf("t3_stall_%0d", s), 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd1}));
      end
      evt_ready = 1'b1;
      tick(1);
      check("t3_second", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd5}));
      tick(1);
      check("t3_empty", 32'(evt_valid), 32'd0);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd5);
      btn_async = '0;
      tick(8);
      check_events("t3");

      // Three presses of button 2 with the consumer stalled
      evt_ready    = 1'b0;
      btn_async[2] = 1'b1;
      tick(8);
      check("t4_held", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd2}));
      btn_async[2] = 1'b0;
      tick(8);
      btn_async[2] = 1'b1;
      tick(8);
      check("t4_ovf_2nd", 32'(overflow), 32'd0);
      btn_async[2] = 1'b0;
      tick(8);
      btn_async[2] = 1'b1;
      tick(8);
      check("t4_ovf_3rd", 32'(overflow), 32'd1);
      btn_async[2] = 1'b0;
      tick(8);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 32'd0);
      evt_ready = 1'b1;
      tick(1);
      check("t4_second", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd2}));
      tick(1);
      check("t4_empty", 32'(evt_valid), 32'd0);
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd2);
      check_events("t4");

      // Reset with an event presented and buttons 1 and 4 pending
      evt_ready    = 1'b0;
      btn_async[6] = 1'b1;
      tick(8);
      check("t5_held", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd6}));
      btn_async[1] = 1'b1;
      btn_async[4] = 1'b1;
      tick(8);
      check("t5_levels", 32'(btn_level), 32'h52);
      rst_n = 1'b0;
      #1;
      check("t5_rst_level", 32'(btn_level), 32'd0);
      check("t5_rst_pulse", 32'(press_pulse), 32'd0);
      check("t5_rst_evt", 32'({evt_valid, evt_idx}), 32'd0);
      check("t5_rst_ovf", 32'(overflow), 32'd0);
      btn_async = '0;
      tick(2);
      rst_n     = 1'b1;
      evt_ready = 1'b1;
      clear_pulses();
      for (int n = 1; n <= 20; n++) begin
         tick(1);
         check($sformatf("t5_quiet_%0d", n), 32'({evt_valid, press_pulse}), 32'd0);
      end
      check_events("t5");

      // Button held through reset release is re-debounced
      rst_n        = 1'b0;
      btn_async[6] = 1'b1;
      tick(3);
      rst_n = 1'b1;
      clear_pulses();
      for (int n = 1; n <= 8; n++) begin
         tick(1);
         check($sformatf("t6_pulse_%0d", n), 32'(press_pulse[6]), 32'(n == 6));
         check($sformatf("t6_lvl_%0d", n), 32'(btn_level[6]), 32'(n >= 6));
      end
      exp_q.push_back(3'd6);
      btn_async = '0;
      tick(8);
      check("t6_npulse", pulse_cnt[6], 1);
      check_events("t6");

      // Press on button 4 in the cycle its pending bit is loaded
      evt_ready    = 1'b0;
      btn_async[0] = 1'b1;
      tick(8);
      check("t7_held", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd0}));
      btn_async[4] = 1'b1;
      tick(8);
      btn_async[4] = 1'b0;
      tick(8);
      btn_async[4] = 1'b1;
      tick(6);
      check("t7_pulse", 32'(press_pulse), 32'h10);
      evt_ready = 1'b1;
      tick(1);
      check("t7_evt_a", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd4}));
      tick(1);
      check("t7_evt_b", 32'({evt_valid, evt_idx}), 32'({1'b1, 3'd4}));
      tick(1);
      check("t7_empty", 32'(evt_valid), 32'd0);
      check("t7_ovf", 32'(overflow), 32'd0);
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd4);
      btn_async = '0;
      tick(8);
      check_events("t7");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
